// File: rtl/tt_pkg.sv
// Shared types and widths for the truth-table capture block.
// Holds the FSM state encoding and mask-width helpers.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } tt_state_t;

    localparam int TT_N = 3;
    localparam int TT_W = 2 ** TT_N;

    function automatic int tt_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/tt_index_counter.sv
// Vector index and per-vector settle counter for the capture sweep.
// Flags the sample cycle of each vector and the final vector.
module tt_index_counter
    import tt_pkg::*;
#(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_en,
    output logic [N-1:0] o_idx,
    output logic         o_sample,
    output logic         o_last
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] RELOAD = SW'(SETTLE);

    logic [SW-1:0] r_settle;
    logic [N-1:0]  r_idx;

    assign o_idx    = r_idx;
    assign o_sample = (r_settle == '0);
    assign o_last   = &r_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_settle <= '0;
        end else if (i_load) begin
            r_idx    <= '0;
            r_settle <= RELOAD;
        end else if (i_en) begin
            if (!o_sample) begin
                r_settle <= r_settle - 1'b1;
            end else if (!o_last) begin
                r_idx    <= r_idx + 1'b1;
                r_settle <= RELOAD;
            end
        end
    end

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all input vectors onto a function under test and captures
// its minterm mask, popcount and comparison against an expected mask.
module truth_table_capture
    import tt_pkg::*;
#(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N-1:0]      vec_out,
    input  logic              s_in,
    input  logic [2**N-1:0]   expected_in,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   table_out,
    output logic [N:0]        ones_count,
    output logic              match
);

    localparam int W = tt_width(N);

    tt_state_t      r_state;
    logic [N-1:0]   r_vec;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_table;
    logic [N:0]     r_ones;
    logic           r_match;

    logic [N-1:0]   w_idx;
    logic           w_sample;
    logic           w_last;
    logic           w_load;
    logic           w_en;

    assign w_load = (r_state == IDLE) && start;
    assign w_en   = (r_state == DRIVE);

    tt_index_counter #(
        .N      (N),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_en     (w_en),
        .o_idx    (w_idx),
        .o_sample (w_sample),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_ones  <= '0;
            r_match <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= DRIVE;
                        r_busy  <= 1'b1;
                        r_vec   <= '0;
                        r_table <= '0;
                        r_ones  <= '0;
                        r_match <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_vec   <= '0;
                        r_table <= '0;
                        r_ones  <= '0;
                        r_match <= 1'b0;
                    end else if (w_sample) begin
                        r_table[w_idx] <= s_in;
                        r_ones <= r_ones + {{N{1'b0}}, s_in};
                        if (w_last) begin
                            r_state <= DONE;
                            r_vec   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_vec <= w_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_match <= (r_table == expected_in);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vec_out    = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign table_out  = r_table;
    assign ones_count = r_ones;
    assign match      = r_match;

endmodule

// File: tb/tb_truth_table_capture.sv
// Self-checking bench: two instances (SETTLE=1 and SETTLE=0) checked
// against a sweep-level reference model of the capture behaviour.
module tb_truth_table_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       use_expr;
    logic       start1, abort1, s1;
    logic       start0, abort0, s0;
    logic [7:0] exp1, exp0, ftbl1, ftbl0;
    logic [2:0] vec1, vec0;
    logic       busy1, done1, match1;
    logic       busy0, done0, match0;
    logic [7:0] tbl1, tbl0;
    logic [3:0] ones1, ones0;

    always_comb begin
        s1 = ftbl1[vec1];
        if (use_expr)
            s1 = (vec1[2] | vec1[1]) & (vec1[1] | ~vec1[0]);
    end

    always_comb s0 = ftbl0[vec0];

    truth_table_capture #(.N(3), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .vec_out(vec1), .s_in(s1), .expected_in(exp1), .busy(busy1),
        .done(done1), .table_out(tbl1), .ones_count(ones1),
        .match(match1)
    );

    truth_table_capture #(.N(3), .SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .vec_out(vec0), .s_in(s0), .expected_in(exp0), .busy(busy0),
        .done(done0), .table_out(tbl0), .ones_count(ones0),
        .match(match0)
    );

    int vectors = 0;
    int miscompares = 0;

    int         obs_vec [0:63];
    int         obs_busy[0:63];
    int         done_cyc, n_done;
    logic       obs_match, obs_done_after;
    logic [7:0] obs_tbl;
    logic [3:0] obs_ones;

    function automatic logic [2:0] get_vec(input int w);
        return (w != 0) ? vec1 : vec0;
    endfunction
    function automatic logic get_busy(input int w);
        return (w != 0) ? busy1 : busy0;
    endfunction
    function automatic logic get_done(input int w);
        return (w != 0) ? done1 : done0;
    endfunction
    function automatic logic get_match(input int w);
        return (w != 0) ? match1 : match0;
    endfunction
    function automatic logic [7:0] get_tbl(input int w);
        return (w != 0) ? tbl1 : tbl0;
    endfunction
    function automatic logic [3:0] get_ones(input int w);
        return (w != 0) ? ones1 : ones0;
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w != 0) start1 = v; else start0 = v;
    endtask
    task automatic set_abort(input int w, input logic v);
        if (w != 0) abort1 = v; else abort0 = v;
    endtask

    // Reference model: sweep length, popcount, expected vector order.
    function automatic int settle_of(input int w);
        return (w != 0) ? 1 : 0;
    endfunction
    function automatic int latency(input int s);
        return 8 * (s + 1) + 1;
    endfunction
    function automatic int pop8(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction
    function automatic logic seq_ok(input int s);
        if (done_cyc < 1) return 1'b0;
        for (int k = 1; k < done_cyc; k++) begin
            if (obs_vec[k] != (k - 1) / (s + 1)) return 1'b0;
            if (obs_busy[k] != 1) return 1'b0;
        end
        return (obs_vec[done_cyc] == 0) && (obs_busy[done_cyc] == 1);
    endfunction

    // Pulses start, then records per-cycle outputs until done or budget.
    task automatic sweep(input int w, input int start_at,
                         input int abort_at, input bit hold,
                         input int max_cyc);
        int cyc;
        done_cyc = -1;
        n_done   = 0;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(w, 1'b0);
        cyc = 1;
        forever begin
            obs_vec[cyc]  = int'(get_vec(w));
            obs_busy[cyc] = int'(get_busy(w));
            if (get_done(w)) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && abort_at < 0) break;
            if (cyc >= max_cyc) break;
            if (cyc == start_at) set_start(w, 1'b1);
            else if (cyc == start_at + 1 && !hold) set_start(w, 1'b0);
            set_abort(w, cyc == abort_at);
            @(posedge clk); #1;
            cyc++;
        end
        set_abort(w, 1'b0);
        obs_tbl  = get_tbl(w);
        obs_ones = get_ones(w);
        obs_match = get_match(w);
        obs_done_after = 1'b0;
        if (done_cyc >= 0 && abort_at < 0) begin
            @(posedge clk); #1;
            obs_match      = get_match(w);
            obs_done_after = get_done(w);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        use_expr = 1'b0;
        start1 = 0; abort1 = 0; exp1 = '0; ftbl1 = '0;
        start0 = 0; abort0 = 0; exp0 = '0; ftbl0 = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({vec1, busy1, done1, tbl1, ones1, match1} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_dut1: got vec=%0d busy=%b done=%b tbl=%h ones=%0d match=%b want all 0",
                     vec1, busy1, done1, tbl1, ones1, match1);
        end
        vectors++;
        if ({vec0, busy0, done0, tbl0, ones0, match0} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_dut0: got vec=%0d busy=%b done=%b tbl=%h ones=%0d match=%b want all 0",
                     vec0, busy0, done0, tbl0, ones0, match0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_expr_match();
        use_expr = 1'b1;
        exp1 = 8'hDC;
        sweep(1, -1, -1, 1'b0, 40);
        vectors++;
        if (done_cyc !== latency(1)) begin
            miscompares++;
            $display("FAIL expr_done_cyc: got %0d want %0d", done_cyc, latency(1));
        end
        vectors++;
        if (seq_ok(1) !== 1'b1) begin
            miscompares++;
            $display("FAIL expr_vec_seq: got bad sequence want 0..7 held 2 cycles");
        end
        vectors++;
        if (obs_tbl !== 8'hDC || obs_ones !== 4'd5) begin
            miscompares++;
            $display("FAIL expr_table: got %h/%0d want dc/5", obs_tbl, obs_ones);
        end
        vectors++;
        if (obs_match !== 1'b1 || obs_done_after !== 1'b0 || n_done !== 1) begin
            miscompares++;
            $display("FAIL expr_match: got match=%b done_after=%b n_done=%0d want 1/0/1",
                     obs_match, obs_done_after, n_done);
        end
    endtask

    task automatic test_expr_mismatch();
        use_expr = 1'b1;
        exp1 = 8'hDD;
        sweep(1, -1, -1, 1'b0, 40);
        vectors++;
        if (obs_tbl !== 8'hDC || obs_ones !== 4'd5) begin
            miscompares++;
            $display("FAIL mism_table: got %h/%0d want dc/5", obs_tbl, obs_ones);
        end
        vectors++;
        if (obs_match !== 1'b0) begin
            miscompares++;
            $display("FAIL mism_match: got %b want 0", obs_match);
        end
    endtask

    task automatic test_ones_zeros();
        ftbl0 = 8'hFF;
        exp0  = 8'hFF;
        sweep(0, -1, -1, 1'b0, 40);
        vectors++;
        if (done_cyc !== latency(0) || seq_ok(0) !== 1'b1) begin
            miscompares++;
            $display("FAIL ones_timing: got done_cyc=%0d want %0d with vec 0..7",
                     done_cyc, latency(0));
        end
        vectors++;
        if (obs_tbl !== 8'hFF || obs_ones !== 4'b1000 || obs_match !== 1'b1) begin
            miscompares++;
            $display("FAIL ones_all: got %h/%0d/%b want ff/8/1",
                     obs_tbl, obs_ones, obs_match);
        end
        ftbl0 = 8'h00;
        exp0  = 8'h5A;
        sweep(0, -1, -1, 1'b0, 40);
        vectors++;
        if (obs_tbl !== 8'h00 || obs_ones !== 4'd0 || obs_match !== 1'b0) begin
            miscompares++;
            $display("FAIL zeros_all: got %h/%0d/%b want 00/0/0",
                     obs_tbl, obs_ones, obs_match);
        end
    endtask

    task automatic test_start_ignored();
        use_expr = 1'b1;
        exp1 = 8'hDC;
        sweep(1, 5, -1, 1'b0, 40);
        vectors++;
        if (done_cyc !== latency(1) || seq_ok(1) !== 1'b1 || n_done !== 1) begin
            miscompares++;
            $display("FAIL start_busy: got done_cyc=%0d n_done=%0d want %0d/1 and clean sequence",
                     done_cyc, n_done, latency(1));
        end
        vectors++;
        if (obs_tbl !== 8'hDC || obs_match !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy_tbl: got %h/%b want dc/1", obs_tbl, obs_match);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int got;
        use_expr = 1'b1;
        exp1 = 8'hDC;
        sweep(1, -1, -1, 1'b1, 40);
        vectors++;
        if (done_cyc !== latency(1) || busy1 !== 1'b0 || obs_match !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: got done_cyc=%0d busy=%b match=%b want %0d/0/1",
                     done_cyc, busy1, obs_match, latency(1));
        end
        @(posedge clk); #1;
        vectors++;
        if (busy1 !== 1'b1 || vec1 !== 3'd0 || match1 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b vec=%0d match=%b want 1/0/0",
                     busy1, vec1, match1);
        end
        start1 = 1'b0;
        got = -1;
        for (c = 1; c <= 40; c++) begin
            if (done1) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (got !== latency(1)) begin
            miscompares++;
            $display("FAIL b2b_second_done: got %0d want %0d", got, latency(1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        use_expr = 1'b1;
        exp1 = 8'hDC;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (vec1 !== 3'd3 || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: got vec=%0d busy=%b want 3/1", vec1, busy1);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({vec1, busy1, done1, tbl1, ones1, match1} !== 18'd0) begin
            miscompares++;
            $display("FAIL arst_now: got vec=%0d busy=%b tbl=%h ones=%0d want all 0",
                     vec1, busy1, tbl1, ones1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        sweep(1, -1, -1, 1'b0, 40);
        vectors++;
        if (done_cyc !== latency(1) || obs_tbl !== 8'hDC ||
            obs_ones !== 4'd5 || obs_match !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_after: got done=%0d tbl=%h ones=%0d match=%b want %0d/dc/5/1",
                     done_cyc, obs_tbl, obs_ones, obs_match, latency(1));
        end
    endtask

    task automatic test_abort();
        use_expr = 1'b1;
        exp1 = 8'hDC;
        abort1 = 1'b1;
        sweep(1, -1, -1, 1'b0, 40);
        vectors++;
        if (done_cyc !== latency(1) || obs_tbl !== 8'hDC) begin
            miscompares++;
            $display("FAIL abort_start_wins: got done=%0d tbl=%h want %0d/dc",
                     done_cyc, obs_tbl, latency(1));
        end
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        vectors++;
        if (tbl1 !== 8'hDC || ones1 !== 4'd5 || match1 !== 1'b1 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got %h/%0d/%b/%b want dc/5/1/0",
                     tbl1, ones1, match1, busy1);
        end
        sweep(1, -1, 9, 1'b0, 14);
        vectors++;
        if (obs_vec[9] !== 4 || obs_busy[10] !== 0 || n_done !== 0) begin
            miscompares++;
            $display("FAIL abort_drive: got vec9=%0d busy10=%0d n_done=%0d want 4/0/0",
                     obs_vec[9], obs_busy[10], n_done);
        end
        vectors++;
        if (obs_tbl !== 8'h00 || obs_ones !== 4'd0 || obs_match !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: got %h/%0d/%b want 00/0/0",
                     obs_tbl, obs_ones, obs_match);
        end
    endtask

    task automatic test_random();
        int w;
        logic [7:0] f;
        logic [7:0] e;
        use_expr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = int'($urandom_range(0, 1));
            f = 8'($urandom);
            e = ($urandom_range(0, 1) != 0) ? f : 8'($urandom);
            if (w != 0) begin ftbl1 = f; exp1 = e; end
            else        begin ftbl0 = f; exp0 = e; end
            sweep(w, -1, -1, 1'b0, 40);
            vectors++;
            if (done_cyc !== latency(settle_of(w)) || seq_ok(settle_of(w)) !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_timing[%0d]: got done_cyc=%0d want %0d",
                         i, done_cyc, latency(settle_of(w)));
            end
            vectors++;
            if (obs_tbl !== f || int'(obs_ones) !== pop8(f) ||
                obs_match !== (f == e)) begin
                miscompares++;
                $display("FAIL rand_result[%0d]: got %h/%0d/%b want %h/%0d/%b",
                         i, obs_tbl, obs_ones, obs_match, f, pop8(f), (f == e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_expr_match();
        test_expr_mismatch();
        test_ones_zeros();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
Sequential reader for the team's 3-variable combinational expression blocks. On `start` it sweeps every input combination onto a function under test and samples its single-bit output. It assembles the captured minterm mask, counts the ones, and compares the mask against an expected table. It lets the boolean-expression modules be checked in hardware instead of only by $monitor truth-table printouts.

Parameters:
- N, 3: number of function inputs; the vector driven is {x,y,z} for N=3, with the MSB as the first variable.
- SETTLE, 1: extra cycles each vector is held before its output is sampled; 0 is legal.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- vec_out  output  N  input combination driven to the function under test.
- s_in  input  1  output of the function under test.
- expected_in  input  2**N  expected minterm mask; sampled at DONE.
- busy  output  1  high while in DRIVE or DONE.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2**N  captured mask; bit i is s_in observed with vec_out == i.
- ones_count  output  N+1  number of set bits in table_out, range 0..2**N.
- match  output  1  table_out == expected_in; valid from the done pulse until the next accepted start.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sweep):
  - state = IDLE.
  - vec_out, busy, done, table_out, ones_count and match all 0.
  - Index and settle counter 0.
- States and transitions:
  - IDLE: `start` moves to DRIVE.
    - On the accepting edge: idx <= 0, settle <= SETTLE, table_out <= 0, ones_count <= 0, match <= 0.
  - DRIVE: vec_out = idx, held for SETTLE+1 cycles.
    - While settle != 0, decrement settle.
    - When settle == 0, on that edge: table_out[idx] <= s_in and ones_count += s_in.
    - If idx == 2**N-1, go to DONE. Otherwise idx += 1 and settle <= SETTLE.
  - DONE: one cycle; done = 1 and match <= (table_out == expected_in). Next state is IDLE.
- Latency:
  - The accepting edge is followed by 2**N*(SETTLE+1) DRIVE cycles and then 1 DONE cycle.
  - N=3, SETTLE=1: done is high in the 17th cycle after the start edge.
- Outputs:
  - vec_out is registered.
  - vec_out returns to 0 in IDLE and DONE.
  - table_out, ones_count and match hold their values in IDLE until the next accepted start.
- Boundary conditions:
  - `start` while busy is ignored, with no restart.
  - `start` high in the same cycle as done is not accepted; it must be seen in IDLE.
  - `abort` in DRIVE: next state IDLE, with no done pulse. table_out, ones_count and match clear to 0.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `start` together in IDLE: start wins.
  - idx wraps never; the last vector ends the sweep.
  - ones_count needs N+1 bits so it can hold 2**N.
  - The ones_count accumulation must not overflow.

Decomposition:
- Shared package (tt_pkg):
  - State encodings IDLE=2'd0, DRIVE=2'd1, DONE=2'd2.
  - Width helper localparam TT_W = 2**N.
- One natural sub-module, tt_index_counter: idx/settle counter with load, enable and last-vector flag. The FSM and the capture registers stay in the top.

Test Plan:
1. Function s=(x|y)&(y|~z), SETTLE=1, expected_in=8'hDC, start pulse -> vec_out steps 0..7, each vector held 2 cycles; done in cycle 17; table_out=8'hDC, ones_count=5, match=1.
2. Same function, expected_in=8'hDD -> table_out=8'hDC, ones_count=5, match=0.
3. s_in tied 1, SETTLE=0 -> done in cycle 9; table_out=8'hFF, ones_count=8 (4'b1000), no overflow. s_in tied 0 -> table_out=8'h00, ones_count=0.
4. Start pulsed again at cycle 5 of a sweep -> ignored; vec_out sequence and done timing unchanged. Start held high through done -> new sweep accepted one cycle after done.
5. Reset asserted asynchronously mid-DRIVE (idx=3) -> outputs 0 immediately. After release, a new start produces the full correct table.
6. Abort at idx=4 -> IDLE next cycle; no done pulse; table_out=0, ones_count=0, match=0.
